// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: func3 encodings, fault causes and
// the FSM state encoding.
`timescale 1ns/1ps
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISAL   = 2'b01;
  localparam logic [1:0] CAUSE_RANGE   = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational legality check of a load/store: func3, alignment and range.
// Reports the highest-priority fault and the access size in bytes.
`timescale 1ns/1ps
module lsu_access_check
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 41
) (
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  output logic        exc,
  output logic [1:0]  cause,
  output logic [2:0]  size
);

  logic        legal;
  logic        misal;
  logic        range_bad;
  logic [32:0] end_addr;

  always_comb begin
    case (func3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
  end

  // Stores have no unsigned variants, and 11 in the low bits is never legal.
  assign legal = (func3[1:0] != 2'b11) &&
                 (we ? (func3[2] == 1'b0) : (!func3[2] || (func3[1:0] != 2'b10)));

  assign misal = ((size == 3'd4) && (addr[1:0] != 2'b00)) ||
                 ((size == 3'd2) && addr[0]);

  // 33-bit sum so addresses near the top of the space cannot wrap into range.
  assign end_addr  = {1'b0, addr} + {30'd0, size};
  assign range_bad = end_addr > 33'(MEM_BYTES);

  always_comb begin
    cause = CAUSE_NONE;
    if (!legal)
      cause = CAUSE_ILLEGAL;
    else if (misal)
      cause = CAUSE_MISAL;
    else if (range_bad)
      cause = CAUSE_RANGE;
  end

  assign exc = (cause != CAUSE_NONE);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives datamem for one cycle,
// and returns an extended load result or a fault to writeback.
`timescale 1ns/1ps
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 41
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_writeEn,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_storeVal,
  input  logic [31:0] mem_loadVal,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_exc,
  output logic [1:0]  rsp_cause
);

  state_t      state_reg, state_next;

  logic        we_reg;
  logic [2:0]  func3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [4:0]  rd_reg;

  logic [31:0] rsp_data_reg;
  logic [4:0]  rsp_rd_reg;
  logic        rsp_exc_reg;
  logic [1:0]  rsp_cause_reg;

  logic        chk_exc;
  logic [1:0]  chk_cause;
  logic [2:0]  chk_size;
  logic [31:0] load_ext;
  logic        accept;

  lsu_access_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .we    (we_reg),
    .func3 (func3_reg),
    .addr  (addr_reg),
    .exc   (chk_exc),
    .cause (chk_cause),
    .size  (chk_size)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    mem_writeEn = 1'b0;
    rsp_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = ACCESS;
      end
      ACCESS: begin
        mem_writeEn = we_reg && !chk_exc;
        state_next  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state_reg == IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      func3_reg <= 3'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rd_reg    <= 5'd0;
    end else if (accept) begin
      we_reg    <= req_we;
      func3_reg <= req_func3;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      rd_reg    <= req_rd;
    end
  end

  assign mem_addr     = addr_reg;
  assign mem_func3    = func3_reg;
  assign mem_storeVal = wdata_reg;

  // Sub-word loads look only at the low lanes; func3[2] selects zero-extension.
  always_comb begin
    load_ext = mem_loadVal;
    case (chk_size)
      3'd1: load_ext = func3_reg[2] ? {24'd0, mem_loadVal[7:0]}
                                    : {{24{mem_loadVal[7]}}, mem_loadVal[7:0]};
      3'd2: load_ext = func3_reg[2] ? {16'd0, mem_loadVal[15:0]}
                                    : {{16{mem_loadVal[15]}}, mem_loadVal[15:0]};
      default: load_ext = mem_loadVal;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_reg  <= 32'd0;
      rsp_rd_reg    <= 5'd0;
      rsp_exc_reg   <= 1'b0;
      rsp_cause_reg <= CAUSE_NONE;
    end else if (state_reg == ACCESS) begin
      rsp_exc_reg   <= chk_exc;
      rsp_cause_reg <= chk_cause;
      rsp_data_reg  <= (chk_exc || we_reg) ? 32'd0 : load_ext;
      rsp_rd_reg    <= (chk_exc || we_reg) ? 5'd0 : rd_reg;
    end
  end

  assign rsp_data  = rsp_data_reg;
  assign rsp_rd    = rsp_rd_reg;
  assign rsp_exc   = rsp_exc_reg;
  assign rsp_cause = rsp_cause_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small byte-addressed datamem model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_writeEn;
  logic [31:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_storeVal;
  logic [31:0] mem_loadVal;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_exc;
  logic [1:0]  rsp_cause;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cycles = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(41)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_writeEn(mem_writeEn), .mem_addr(mem_addr), .mem_func3(mem_func3),
    .mem_storeVal(mem_storeVal), .mem_loadVal(mem_loadVal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_exc(rsp_exc), .rsp_cause(rsp_cause)
  );

  // Datamem model: 64 bytes, little-endian, combinational read of 4 bytes at mem_addr.
  logic [7:0]  mem [0:63];
  logic [31:0] garbage_mask = 32'd0;

  always_comb begin
    logic [31:0] a;
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      a = mem_addr + 32'(i);
      w[8*i +: 8] = (a < 32'd64) ? mem[a[5:0]] : 8'h00;
    end
    mem_loadVal = w ^ garbage_mask;
  end

  always @(posedge clk) begin
    if (mem_writeEn) begin
      we_cycles++;
      for (int i = 0; i < 4; i++) begin
        if ((i < 1 || mem_func3[1:0] != 2'b00) && (i < 2 || mem_func3[1:0] == 2'b10)
            && (mem_addr + 32'(i) < 32'd64))
          mem[6'(mem_addr + 32'(i))] <= mem_storeVal[8*i +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
    logic [1:0]  cause;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted response against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data=%h with empty scoreboard", rsp_data);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rsp"}, {rsp_data, rsp_rd, rsp_exc, rsp_cause},
            {e.data, e.rd, e.exc, e.cause});
        $display("rsp %-12s data=%h rd=%0d exc=%0b cause=%b",
                 e.name, rsp_data, rsp_rd, rsp_exc, rsp_cause);
      end
    end
  end

  task automatic chk_reset(input string name);
    chk({name, "_ready"}, 128'(req_ready), 128'(1));
    chk({name, "_outs"}, 128'({mem_writeEn, mem_addr, mem_func3, mem_storeVal,
                               rsp_valid, rsp_data, rsp_rd, rsp_exc, rsp_cause}), 128'(0));
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, "_ready_wait"}, 128'(req_ready), 128'(1));
  endtask

  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] exp_data,
                        input logic [1:0] exp_cause, input int hold);
    int          wc0;
    logic        exp_exc;
    logic [42:0] snap;
    exp_exc = (exp_cause != CAUSE_NONE);
    wait_ready(name);
    req_valid = 1'b1; req_we = we; req_func3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    rsp_ready = (hold == 0);
    sb.push_back('{data: exp_data, rd: (we || exp_exc) ? 5'd0 : rd,
                   exc: exp_exc, cause: exp_cause, name: name});
    wc0 = we_cycles;
    @(posedge clk); #1;
    // Junk on the request bus while busy must be ignored.
    req_we = ~we; req_func3 = 3'b111; req_addr = 32'h3; req_wdata = 32'h0; req_rd = 5'd31;
    chk({name, "_wen_access"}, 128'(mem_writeEn), 128'(we && !exp_exc));
    chk({name, "_maddr"}, 128'(mem_addr), 128'(addr));
    chk({name, "_valid_early"}, 128'(rsp_valid), 128'(0));
    @(posedge clk); #1;
    chk({name, "_valid_e1"}, 128'({rsp_valid, mem_writeEn}), 128'(2'b10));
    snap = {rsp_valid, rsp_data, rsp_rd, rsp_exc, rsp_cause, req_ready};
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "_hold"}, 128'({rsp_valid, rsp_data, rsp_rd, rsp_exc, rsp_cause, req_ready}),
          128'(snap));
      chk({name, "_hold_rdy"}, 128'(req_ready), 128'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_ready_after"}, 128'({req_ready, rsp_valid}), 128'(2'b10));
    chk({name, "_wen_cycles"}, 128'(we_cycles - wc0), 128'(we && !exp_exc));
    req_valid = 1'b0;
    $display("req %-12s we=%0b f3=%b addr=%h wdata=%h", name, we, f3, addr, wdata);
  endtask

  initial begin
    int wc0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    #2;
    chk_reset("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("post_reset");

    do_req("sw_8",    1'b1, F3_SW, 32'd8, 32'hDEADBEEF, 5'd0, 32'h0, CAUSE_NONE, 0);
    do_req("lw_8",    1'b0, F3_LW, 32'd8, 32'h0, 5'd5, 32'hDEADBEEF, CAUSE_NONE, 0);

    do_req("sb_3",    1'b1, F3_SB, 32'd3, 32'h12345680, 5'd0, 32'h0, CAUSE_NONE, 0);
    garbage_mask = 32'hC3C3C300;
    do_req("lb_3",    1'b0, F3_LB,  32'd3, 32'h0, 5'd1, 32'hFFFFFF80, CAUSE_NONE, 0);
    do_req("lbu_3",   1'b0, F3_LBU, 32'd3, 32'h0, 5'd2, 32'h00000080, CAUSE_NONE, 0);
    garbage_mask = 32'h0;

    do_req("sh_4",    1'b1, F3_SH, 32'd4, 32'hCAFE8001, 5'd0, 32'h0, CAUSE_NONE, 0);
    garbage_mask = 32'h5A5A0000;
    do_req("lh_4",    1'b0, F3_LH,  32'd4, 32'h0, 5'd3, 32'hFFFF8001, CAUSE_NONE, 0);
    do_req("lhu_4",   1'b0, F3_LHU, 32'd4, 32'h0, 5'd4, 32'h00008001, CAUSE_NONE, 0);
    garbage_mask = 32'h0;

    do_req("lw_6",    1'b0, F3_LW, 32'd6, 32'h0, 5'd7, 32'h0, CAUSE_MISAL, 0);
    // 38 is not word-aligned, so misalignment outranks the range fault.
    do_req("sw_38",   1'b1, F3_SW, 32'd38, 32'h55555555, 5'd0, 32'h0, CAUSE_MISAL, 0);
    do_req("sb_40",   1'b1, F3_SB, 32'd40, 32'h0000007F, 5'd0, 32'h0, CAUSE_NONE, 0);
    do_req("sw_40",   1'b1, F3_SW, 32'd40, 32'hFFFFFFFF, 5'd0, 32'h0, CAUSE_RANGE, 0);
    do_req("lb_40",   1'b0, F3_LB, 32'd40, 32'h0, 5'd10, 32'h0000007F, CAUSE_NONE, 0);
    do_req("lh_40",   1'b0, F3_LH, 32'd40, 32'h0, 5'd11, 32'h0, CAUSE_RANGE, 0);
    do_req("ld011_0", 1'b0, 3'b011, 32'd0, 32'h0, 5'd12, 32'h0, CAUSE_ILLEGAL, 0);
    do_req("ld111_1", 1'b0, 3'b111, 32'd1, 32'h0, 5'd13, 32'h0, CAUSE_ILLEGAL, 0);
    do_req("st100_0", 1'b1, 3'b100, 32'd0, 32'h0, 5'd0, 32'h0, CAUSE_ILLEGAL, 0);
    do_req("lh_top",  1'b0, F3_LH, 32'hFFFFFFFE, 32'h0, 5'd14, 32'h0, CAUSE_RANGE, 0);

    do_req("lw_8_bp", 1'b0, F3_LW, 32'd8, 32'h0, 5'd15, 32'hDEADBEEF, CAUSE_NONE, 5);

    do_req("sw_12",   1'b1, F3_SW, 32'd12, 32'h11223344, 5'd0, 32'h0, CAUSE_NONE, 0);
    wait_ready("sw_12_rst");
    req_valid = 1'b1; req_we = 1'b1; req_func3 = F3_SW;
    req_addr = 32'd12; req_wdata = 32'hAAAAAAAA; req_rd = 5'd0;
    wc0 = we_cycles;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_access_wen", 128'(mem_writeEn), 128'(1));
    @(negedge clk); rst_n = 1'b0; #1;
    chk_reset("rst_in_access");
    @(posedge clk); #1;
    chk_reset("rst_held");
    chk("rst_no_commit", 128'(we_cycles - wc0), 128'(0));
    $display("req %-12s reset pulse during ACCESS", "sw_12_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_req("lw_12",   1'b0, F3_LW, 32'd12, 32'h0, 5'd16, 32'h11223344, CAUSE_NONE, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
